// File: rtl/counter_with_preset.sv
// Up/down counter with terminal value, synchronous clear, clamped preset load and a registered wrap flag.
// Define COUNTER_WITH_PRESET_SATURATE_EN to saturate at the limits instead of wrapping.
module counter_with_preset #(
  parameter int bits     = 4,
  parameter int maxvalue = 0
) (
  input  logic            c,
  input  logic            rst_n,
  input  logic            en,
  input  logic            clr,
  input  logic            dir,
  input  logic            ld,
  input  logic [bits-1:0] in,
  output logic [bits-1:0] out,
  output logic            ovf
);

  // maxvalue = 0 selects the full range of the counter
  localparam logic [bits-1:0] term = (maxvalue == 0) ? {bits{1'b1}} : bits'(maxvalue);

`ifdef COUNTER_WITH_PRESET_SATURATE_EN
  localparam logic saturate = 1'b1;
`else
  localparam logic saturate = 1'b0;
`endif

  logic [bits-1:0] count_reg, count_next;
  logic            ovf_reg, ovf_next;

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      ovf_reg   <= ovf_next;
    end
  end

  always_comb begin
    count_next = count_reg;
    ovf_next   = 1'b0;
    if (clr) begin
      count_next = '0;
    end else if (ld) begin
      count_next = (in > term) ? term : in;
    end else if (en) begin
      if (!dir) begin
        // values above term (only after re-parameterisation) behave like term
        if (count_reg >= term) begin
          count_next = saturate ? term : '0;
          ovf_next   = 1'b1;
        end else begin
          count_next = count_reg + bits'(1);
        end
      end else begin
        if (count_reg == '0) begin
          count_next = saturate ? '0 : term;
          ovf_next   = 1'b1;
        end else begin
          count_next = count_reg - bits'(1);
        end
      end
    end
  end

  assign out = count_reg;
  assign ovf = ovf_reg;

endmodule

// File: tb/tb_counter_with_preset.sv
// Drives a full-range (M=7) and a short-range (M=5) 3-bit counter in lockstep and
// compares both against an arithmetic model of the counting rules.
module tb_counter_with_preset;

  logic       c = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, clr = 1'b0, dir = 1'b0, ld = 1'b0;
  logic [2:0] in = 3'd0;
  logic [2:0] out_a, out_b;
  logic       ovf_a, ovf_b;

  int passed = 0;
  int total  = 0;
  int m_out [2];
  int m_ovf [2];
  int m_max [2] = '{7, 5};

`ifdef COUNTER_WITH_PRESET_SATURATE_EN
  localparam bit sat = 1'b1;
`else
  localparam bit sat = 1'b0;
`endif

  always #5 c = ~c;

  counter_with_preset #(.bits(3), .maxvalue(0)) dut_a (
    .c(c), .rst_n(rst_n), .en(en), .clr(clr), .dir(dir), .ld(ld), .in(in),
    .out(out_a), .ovf(ovf_a)
  );

  counter_with_preset #(.bits(3), .maxvalue(5)) dut_b (
    .c(c), .rst_n(rst_n), .en(en), .clr(clr), .dir(dir), .ld(ld), .in(in),
    .out(out_b), .ovf(ovf_b)
  );

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    check({tag, " out_a"}, int'(out_a), m_out[0]);
    check({tag, " ovf_a"}, int'(ovf_a), m_ovf[0]);
    check({tag, " out_b"}, int'(out_b), m_out[1]);
    check({tag, " ovf_b"}, int'(ovf_b), m_ovf[1]);
    $display("%0t %-8s en=%b clr=%b dir=%b ld=%b in=%0d | a=%0d/%b b=%0d/%b",
             $time, tag, en, clr, dir, ld, in, out_a, ovf_a, out_b, ovf_b);
  endtask

  // Next state from the behavioural rules: clear, clamped load, count with wrap/saturate, hold.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int mx = m_max[k];
      m_ovf[k] = 0;
      if (clr) m_out[k] = 0;
      else if (ld) m_out[k] = (int'(in) > mx) ? mx : int'(in);
      else if (en && !dir) begin
        if (m_out[k] >= mx) begin m_out[k] = sat ? mx : 0; m_ovf[k] = 1; end
        else m_out[k] = m_out[k] + 1;
      end else if (en && dir) begin
        if (m_out[k] == 0) begin m_out[k] = sat ? 0 : mx; m_ovf[k] = 1; end
        else m_out[k] = m_out[k] - 1;
      end
    end
  endtask

  task automatic step(input string tag, input logic e, input logic cl, input logic d,
                      input logic l, input logic [2:0] v);
    en = e; clr = cl; dir = d; ld = l; in = v;
    @(posedge c);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin m_out[k] = 0; m_ovf[k] = 0; end
    #12;
    check_all("reset");
    @(negedge c);
    rst_n = 1'b1;

    // 1: async reset mid-count, then synchronous clear
    for (int i = 0; i < 3; i++) step("up_pre", 1, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin m_out[k] = 0; m_ovf[k] = 0; end
    check_all("async");
    @(posedge c); #1;
    check_all("rst_hold");
    @(negedge c);
    rst_n = 1'b1;
    step("clr", 1, 1, 0, 0, 0);

    // 2: ten up edges through a wrap
    for (int i = 0; i < 10; i++) step("up", 1, 0, 0, 0, 0);

    // 3: load 3 with en high, then five up edges
    step("ld3", 1, 0, 0, 1, 3'd3);
    for (int i = 0; i < 5; i++) step("up", 1, 0, 0, 0, 0);

    // 4: from zero count down ten edges
    step("clr", 0, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) step("down", 1, 0, 1, 0, 0);

    // 5: short range wrap, clamp on load, underflow
    step("ld4", 0, 0, 0, 1, 3'd4);
    for (int i = 0; i < 3; i++) step("up", 1, 0, 0, 0, 0);
    step("ld7", 0, 0, 0, 1, 3'd7);
    step("clr", 0, 1, 0, 0, 0);
    step("down0", 1, 0, 1, 0, 0);

    // 6: clr beats ld, ld without en, hold
    step("clr_ld", 1, 1, 0, 1, 3'd6);
    step("ld_noen", 0, 0, 1, 1, 3'd6);
    for (int i = 0; i < 3; i++) step("hold", 0, 0, 0, 0, 0);
    step("dirflip", 1, 0, 1, 0, 0);
    step("dirflip", 1, 0, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 200; i++) begin
      step("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
           1'($urandom), 1'($urandom_range(0, 7) == 0), 3'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
